bpred_tournament_gshare: RTL

//  Parametrised tournament branch predictor: local history (BHT+PHTl), gshare global predictor (GHR^PC->PHTg), chooser (CPHT).

---
 rtl/bpred_tournament_gshare.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bpred_tournament_gshare.sv
// Tournament branch predictor: per-PC local history (BHT -> PHTl), gshare
// global predictor (GHR ^ PC -> PHTg) and a 2-bit chooser (CPHT) indexed by GHR.
// Predicts in F, registers into D, checks in E, flags a mispredict at M entry,
// trains in M using the table indices carried down the pipe.
// Optional build macro: BPRED_STATS_EN adds saturating branch/mispredict counters.
module bpred_tournament_gshare #(
  parameter int BHT_BITS   = 10,
  parameter int LHIST_BITS = 6,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int GSHARE     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic        flushE,
  input  logic        flushM,
  input  logic [31:0] pcF,
  input  logic        branchD,
  input  logic        branchE,
  input  logic        branchM,
  input  logic        actual_takeE,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        pred_wrongM,
  output logic        pred_takeD_loc,
  output logic        pred_takeD_glo
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int BHT_ENTRIES  = 1 << BHT_BITS;
  localparam int PHTL_ENTRIES = 1 << LHIST_BITS;
  localparam int GLOB_ENTRIES = 1 << GHR_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX    = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO   = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE    = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [1:0]          CHO_WEAK_L = 2'b10;

  // Saturating up/down step of a direction counter.
  function automatic logic [CTR_BITS-1:0] ctrStep(input logic [CTR_BITS-1:0] ctr, input logic up);
    logic [CTR_BITS-1:0] res;
    if (up && (ctr != CTR_MAX)) begin
      res = ctr + CTR_ONE;
    end else if (!up && (ctr != CTR_ZERO)) begin
      res = ctr - CTR_ONE;
    end else begin
      res = ctr;
    end
    return res;
  endfunction

  // Chooser moves only when exactly one component was right (MSB 1 = local).
  function automatic logic [1:0] choStep(input logic [1:0] cho, input logic locRight, input logic gloRight);
    logic [1:0] res;
    case ({locRight, gloRight})
      2'b10:   res = (cho != 2'b11) ? cho + 2'b01 : cho;
      2'b01:   res = (cho != 2'b00) ? cho - 2'b01 : cho;
      default: res = cho;
    endcase
    return res;
  endfunction

  typedef struct packed {
    logic                  loc;
    logic                  glo;
    logic                  choose;
    logic [BHT_BITS-1:0]   bhtIdx;
    logic [LHIST_BITS-1:0] lidx;
    logic [GHR_BITS-1:0]   gidx;
    logic [GHR_BITS-1:0]   cidx;
    logic [GHR_BITS-1:0]   snap;
  } predStageT;

  typedef struct packed {
    logic                  wrongFin;
    logic                  wrongLoc;
    logic                  wrongGlo;
    logic [BHT_BITS-1:0]   bhtIdx;
    logic [LHIST_BITS-1:0] lidx;
    logic [GHR_BITS-1:0]   gidx;
    logic [GHR_BITS-1:0]   cidx;
    logic [GHR_BITS-1:0]   snap;
  } trainStageT;

  logic [LHIST_BITS-1:0] bhtR  [BHT_ENTRIES];
  logic [CTR_BITS-1:0]   phtLR [PHTL_ENTRIES];
  logic [CTR_BITS-1:0]   phtGR [GLOB_ENTRIES];
  logic [1:0]            cphtR [GLOB_ENTRIES];
  logic [GHR_BITS-1:0]   ghrR;

  predStageT  fdR, deR, fdNextS;
  trainStageT emR, emNextS;

  logic [BHT_BITS-1:0]   bhtIdxF;
  logic [LHIST_BITS-1:0] bhrF;
  logic [GHR_BITS-1:0]   pcHashF;
  logic                  predFinE;
  logic [LHIST_BITS-1:0] bhrNextS;
  logic [CTR_BITS-1:0]   phtLNextS;
  logic [CTR_BITS-1:0]   phtGNextS;
  logic [1:0]            choNextS;
  logic                  unusedPc;

  // Only a slice of the PC feeds the indices; the rest is deliberately ignored.
  assign unusedPc = ^pcF;

  // F: read all tables combinationally and assemble the F->D payload.
  always_comb begin
    fdNextS = '0;
    bhtIdxF = pcF[BHT_BITS+1:2];
    bhrF    = bhtR[bhtIdxF];
    pcHashF = (GSHARE != 0) ? pcF[GHR_BITS+1:2] : {GHR_BITS{1'b0}};
    fdNextS.bhtIdx = bhtIdxF;
    fdNextS.lidx   = bhrF;
    fdNextS.gidx   = ghrR ^ pcHashF;
    fdNextS.cidx   = ghrR;
    fdNextS.snap   = ghrR;
    fdNextS.loc    = phtLR[bhrF][CTR_BITS-1];
    fdNextS.glo    = phtGR[ghrR ^ pcHashF][CTR_BITS-1];
    fdNextS.choose = cphtR[ghrR][1];
  end

  // F->D stage register: flush clears, stall holds.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      fdR <= '0;
    end else if (!stallD) begin
      fdR <= fdNextS;
    end else begin
      fdR <= fdR;
    end
  end

  assign pred_takeD_loc = branchD & fdR.loc;
  assign pred_takeD_glo = branchD & fdR.glo;
  assign pred_takeD     = branchD & (fdR.choose ? fdR.loc : fdR.glo);

  // D->E stage register, loads every cycle.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      deR <= '0;
    end else begin
      deR <= fdR;
    end
  end

  // E: compare each prediction with the resolved direction.
  always_comb begin
    emNextS  = '0;
    predFinE = deR.choose ? deR.loc : deR.glo;
    emNextS.wrongFin = branchE & (predFinE != actual_takeE);
    emNextS.wrongLoc = branchE & (deR.loc  != actual_takeE);
    emNextS.wrongGlo = branchE & (deR.glo  != actual_takeE);
    emNextS.bhtIdx   = deR.bhtIdx;
    emNextS.lidx     = deR.lidx;
    emNextS.gidx     = deR.gidx;
    emNextS.cidx     = deR.cidx;
    emNextS.snap     = deR.snap;
  end

  // E->M stage register, loads every cycle.
  always_ff @(posedge clk) begin
    if (rst || flushM) begin
      emR <= '0;
    end else begin
      emR <= emNextS;
    end
  end

  assign pred_wrongM = emR.wrongFin;

  // Speculative global history; repair from the M snapshot overrides a D shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghrR <= {GHR_BITS{1'b0}};
    end else if (emR.wrongFin) begin
      ghrR <= {emR.snap[GHR_BITS-2:0], actual_takeM};
    end else if (branchD && !stallD) begin
      ghrR <= {ghrR[GHR_BITS-2:0], pred_takeD};
    end else begin
      ghrR <= ghrR;
    end
  end

  // M: compute the trained values of the entries addressed by the carried indices.
  always_comb begin
    bhrNextS  = {emR.lidx[LHIST_BITS-2:0], actual_takeM};
    phtLNextS = ctrStep(phtLR[emR.lidx], actual_takeM);
    phtGNextS = ctrStep(phtGR[emR.gidx], actual_takeM);
    choNextS  = choStep(cphtR[emR.cidx], ~emR.wrongLoc, ~emR.wrongGlo);
  end

  for (genvar i = 0; i < BHT_ENTRIES; i++) begin : gBht
    // Local history entry: reset to 0, shift in the outcome when trained.
    always_ff @(posedge clk) begin
      if (rst) begin
        bhtR[i] <= {LHIST_BITS{1'b0}};
      end else if (branchM && (emR.bhtIdx == BHT_BITS'(i))) begin
        bhtR[i] <= bhrNextS;
      end
    end
  end

  for (genvar i = 0; i < PHTL_ENTRIES; i++) begin : gPhtL
    // Local PHT counter: reset weakly taken, saturating training.
    always_ff @(posedge clk) begin
      if (rst) begin
        phtLR[i] <= CTR_WEAK_T;
      end else if (branchM && (emR.lidx == LHIST_BITS'(i))) begin
        phtLR[i] <= phtLNextS;
      end
    end
  end

  for (genvar i = 0; i < GLOB_ENTRIES; i++) begin : gGlob
    // Global PHT counter: reset weakly taken, saturating training.
    always_ff @(posedge clk) begin
      if (rst) begin
        phtGR[i] <= CTR_WEAK_T;
      end else if (branchM && (emR.gidx == GHR_BITS'(i))) begin
        phtGR[i] <= phtGNextS;
      end
    end

    // Chooser counter: reset weakly local, moves toward the component that was right.
    always_ff @(posedge clk) begin
      if (rst) begin
        cphtR[i] <= CHO_WEAK_L;
      end else if (branchM && (emR.cidx == GHR_BITS'(i))) begin
        cphtR[i] <= choNextS;
      end
    end
  end

`ifdef BPRED_STATS_EN
  // Saturating counters of trained branches and final mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= 32'h0000_0000;
      stat_mispred  <= 32'h0000_0000;
    end else begin
      if (branchM && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'h0000_0001;
      end
      if (pred_wrongM && (stat_mispred != 32'hFFFF_FFFF)) begin
        stat_mispred <= stat_mispred + 32'h0000_0001;
      end
    end
  end
`endif

endmodule
